// File: rtl/csa_stream_accumulator.sv
// Unsigned stream accumulator that keeps a redundant sum/carry pair, so each beat
// costs one full-adder level. One carry-propagate add resolves each packet's total.
module csa_stream_accumulator #(
    parameter int WIDTH = 16,
    parameter int GUARD = 8,
    parameter int CNT_W = 16,
    localparam int ACC_W = WIDTH + GUARD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             overflow
);

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   s_q, c_q;
    logic               dropped_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic [CNT_W-1:0]   out_count_q;
    logic               overflow_q;

    logic [ACC_W-1:0]   d_ext;
    logic [ACC_W-1:0]   s_d, k_d, c_d;
    logic               dropped_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [ACC_W-1:0]   sum_r;
    logic               cout;

    // One 3:2 compressor level: returns {majority, parity} per bit.
    function automatic logic [2*ACC_W-1:0] csa32(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b,
                                                 input logic [ACC_W-1:0] c);
        logic [ACC_W-1:0] s, k;
        s = a ^ b ^ c;
        k = (a & b) | (a & c) | (b & c);
        return {k, s};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    assign d_ext      = {{GUARD{1'b0}}, in_data};
    assign {k_d, s_d} = csa32(s_q, c_q, d_ext);
    // The carry leaving the top bit would be lost by the shift, so it is recorded as overflow.
    assign c_d        = {k_d[ACC_W-2:0], 1'b0};
    assign dropped_d  = dropped_q | k_d[ACC_W-1];
    assign cnt_d      = sat_inc(cnt_q);
    assign {cout, sum_r} = {1'b0, s_q} + {1'b0, c_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            dropped_q   <= 1'b0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        s_q       <= s_d;
                        c_q       <= c_d;
                        dropped_q <= dropped_d;
                        cnt_q     <= cnt_d;
                        if (in_last) state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    out_sum_q   <= sum_r;
                    out_count_q <= cnt_q;
                    overflow_q  <= dropped_q | cout;
                    s_q         <= '0;
                    c_q         <= '0;
                    dropped_q   <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) state_q <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign overflow  = overflow_q;

endmodule
